pcpu_dcache: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate data cache for the next-generation pipelined CPU.

---
 rtl/pcpu_dcache_pkg.sv | 21 ++
 rtl/pcpu_dcache_if.sv | 18 +
 rtl/pcpu_dcache_array.sv | 40 ++++
 rtl/pcpu_dcache.sv | 208 ++++++++++++++++++++
 tb/tb_pcpu_dcache.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcpu_dcache_pkg.sv
// pcpu_dcache_pkg: default widths, FSM encoding and helpers shared by the data cache files.
package pcpu_dcache_pkg;

    localparam int unsigned DC_DATA_W   = 16;
    localparam int unsigned DC_ADDR_W   = 16;
    localparam int unsigned DC_INDEX_W  = 4;
    localparam int unsigned DC_OFFSET_W = 1;
    localparam int unsigned DC_STAT_W   = 16;

    typedef enum logic [1:0] {
        DC_IDLE   = 2'd0,
        DC_REFILL = 2'd1,
        DC_WRITE  = 2'd2
    } dc_state_e;

    // Saturating increment used by the hit/miss statistics counters.
    function automatic logic [DC_STAT_W-1:0] sat_inc(input logic [DC_STAT_W-1:0] v);
        return (v == '1) ? v : v + DC_STAT_W'(1);
    endfunction

endpackage

// File: rtl/pcpu_dcache_if.sv
// pcpu_dcache_if: request/ready word bus, used for both the CPU side and the memory side.
// On the memory side "ready" carries the memory ack.
interface pcpu_dcache_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/pcpu_dcache_array.sv
// pcpu_dcache_array: data and tag storage with one shared write port and asynchronous reads.
// Contents are intentionally not reset; validity lives in the parent.
module pcpu_dcache_array #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TAG_W    = 11,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 1,
    parameter int unsigned WORD_AW  = INDEX_W + OFFSET_W
) (
    input  logic               clock,
    input  logic               we,
    input  logic               tag_we,
    input  logic [WORD_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [WORD_AW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata,
    output logic [TAG_W-1:0]   rtag
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << WORD_AW;

    logic [DATA_W-1:0] data_mem [WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];

    // Word write, with the line tag written alongside on the final refill word.
    always_ff @(posedge clock) begin
        if (we) begin
            data_mem[waddr] <= wdata;
        end
        if (tag_we) begin
            tag_mem[INDEX_W'(waddr >> OFFSET_W)] <= wtag;
        end
    end

    assign rdata = data_mem[raddr];
    assign rtag  = tag_mem[INDEX_W'(raddr >> OFFSET_W)];

endmodule

// File: rtl/pcpu_dcache.sv
// pcpu_dcache: direct-mapped, write-through, no-write-allocate data cache between MEM stage and memory.
// Optional DCACHE_STATS_EN adds saturating load hit/miss counters (hit_cnt, miss_cnt).
module pcpu_dcache
    import pcpu_dcache_pkg::*;
#(
    parameter int unsigned DATA_W   = DC_DATA_W,
    parameter int unsigned ADDR_W   = DC_ADDR_W,
    parameter int unsigned INDEX_W  = DC_INDEX_W,
    parameter int unsigned OFFSET_W = DC_OFFSET_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    pcpu_dcache_if.slave  cpu,
    pcpu_dcache_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [DC_STAT_W-1:0] hit_cnt,
    output logic [DC_STAT_W-1:0] miss_cnt
`endif
);

    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WORD_AW = INDEX_W + OFFSET_W;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned WORDS   = 1 << OFFSET_W;
    localparam int unsigned CNT_W   = (OFFSET_W > 0) ? OFFSET_W : 1;

    dc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic               flush_pend_q, flush_pend_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               ready;

    logic [TAG_W-1:0]   tag, rtag;
    logic [INDEX_W-1:0] index;
    logic [ADDR_W-1:0]  line_base;
    logic               hit;
    logic               arr_we, arr_tag_we;
    logic [WORD_AW-1:0] arr_waddr;
    logic [DATA_W-1:0]  arr_wdata, arr_rdata;

    assign tag       = TAG_W'(cpu.addr >> (INDEX_W + OFFSET_W));
    assign index     = INDEX_W'(cpu.addr >> OFFSET_W);
    assign line_base = (cpu.addr >> OFFSET_W) << OFFSET_W;
    assign hit       = valid_q[index] && (rtag == tag);
    assign cnt_nxt   = cnt_q + CNT_W'(1);

    pcpu_dcache_array #(
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .WORD_AW  (WORD_AW)
    ) u_array (
        .clock  (clock),
        .we     (arr_we),
        .tag_we (arr_tag_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .wtag   (tag),
        .raddr  (WORD_AW'(cpu.addr)),
        .rdata  (arr_rdata),
        .rtag   (rtag)
    );

    // State, valid bits and registered memory-side outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= DC_IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next-state, cache array writes and CPU handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ready        = 1'b0;
        arr_we       = 1'b0;
        arr_tag_we   = 1'b0;
        arr_waddr    = WORD_AW'(cpu.addr);
        arr_wdata    = cpu.wdata;

        unique case (state_q)
            DC_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (!cpu.req) begin
                    ready = 1'b1;
                end else if (!cpu.we) begin
                    if (hit) begin
                        ready = 1'b1;
                    end else begin
                        state_d    = DC_REFILL;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_base;
                    end
                end else begin
                    state_d     = DC_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cpu.addr;
                    mem_wdata_d = cpu.wdata;
                end
            end
            DC_REFILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem.ready) begin
                    arr_we    = 1'b1;
                    arr_waddr = WORD_AW'(mem_addr_q);
                    arr_wdata = mem.rdata;
                    if (cnt_q == CNT_W'(WORDS - 1)) begin
                        arr_tag_we   = 1'b1;
                        state_d      = DC_IDLE;
                        mem_req_d    = 1'b0;
                        flush_pend_d = 1'b0;
                        // A flush seen during the refill leaves every line, this one included, invalid.
                        if (flush_pend_q || flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[index] = 1'b1;
                        end
                    end else begin
                        cnt_d      = cnt_nxt;
                        mem_addr_d = line_base | ADDR_W'(cnt_nxt);
                    end
                end
            end
            DC_WRITE: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem.ready) begin
                    ready        = 1'b1;
                    arr_we       = hit;
                    state_d      = DC_IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    flush_pend_d = 1'b0;
                    if (flush_pend_q || flush) begin
                        valid_d = '0;
                    end
                end
            end
            default: begin
                state_d = DC_IDLE;
            end
        endcase
    end

    assign cpu.ready = ready && reset;
    assign cpu.rdata = arr_rdata;
    assign mem.req   = mem_req_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic refilled_q;

    // Load hit/miss counters; the retry that follows a refill is not a hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            refilled_q <= 1'b0;
        end else begin
            refilled_q <= (state_q == DC_REFILL) && (state_d == DC_IDLE);
            if ((state_q == DC_IDLE) && (state_d == DC_REFILL)) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
            if ((state_q == DC_IDLE) && cpu.req && !cpu.we && ready && !refilled_q) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcpu_dcache.sv
// tb_pcpu_dcache: directed scoreboard bench for pcpu_dcache (INDEX_W=4, OFFSET_W=1).
module tb_pcpu_dcache;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_exp_t;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
    } cpu_exp_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    always #5 clock = ~clock;

    pcpu_dcache_if #(.DATA_W(16), .ADDR_W(16)) cpu_bus ();
    pcpu_dcache_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    pcpu_dcache #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .INDEX_W  (4),
        .OFFSET_W (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int checks    = 0;
    int failures  = 0;
    int ack_delay = 2;
    int wcnt      = 0;

    mem_exp_t exp_mem [$];
    cpu_exp_t exp_cpu [$];
    logic [15:0] written [logic [15:0]];
    mem_exp_t me;
    cpu_exp_t ce;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        case (a)
            16'h0012: return 16'hAAAA;
            16'h0013: return 16'hBBBB;
            16'h0212: return 16'hCCCC;
            16'h0213: return 16'hDDDD;
            16'h0040: return 16'h4040;
            16'h0041: return 16'h4141;
            16'h0240: return 16'h2400;
            16'h0241: return 16'h2401;
            default:  return 16'h0000;
        endcase
    endfunction

    // Memory responder: acks ack_delay cycles after a request starts, stores take effect on ack.
    always @(negedge clock) begin
        mem_bus.ready = 1'b0;
        if (mem_bus.req) begin
            if (wcnt >= ack_delay) begin
                mem_bus.ready = 1'b1;
                mem_bus.rdata = written.exists(mem_bus.addr) ? written[mem_bus.addr]
                                                             : init_val(mem_bus.addr);
                if (mem_bus.we) written[mem_bus.addr] = mem_bus.wdata;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: pops expected memory transactions and CPU completions as they appear.
    always @(negedge clock) begin
        #2;
        if (mem_bus.req && mem_bus.ready) begin
            checks++;
            if (exp_mem.size() == 0) begin
                failures++;
                $display("FAIL mem_txn: unexpected we=%0b addr=%h", mem_bus.we, mem_bus.addr);
            end else begin
                me = exp_mem.pop_front();
                if (mem_bus.we !== me.we || mem_bus.addr !== me.addr ||
                    (me.we && mem_bus.wdata !== me.data)) begin
                    failures++;
                    $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                             mem_bus.we, mem_bus.addr, mem_bus.wdata, me.we, me.addr, me.data);
                end
            end
        end
        if (cpu_bus.req && cpu_bus.ready) begin
            checks++;
            if (exp_cpu.size() == 0) begin
                failures++;
                $display("FAIL cpu_resp: unexpected completion addr=%h", cpu_bus.addr);
            end else begin
                ce = exp_cpu.pop_front();
                if (cpu_bus.we !== ce.we || (!ce.we && cpu_bus.rdata !== ce.data)) begin
                    failures++;
                    $display("FAIL cpu_resp: got we=%0b rdata=%h want we=%0b rdata=%h",
                             cpu_bus.we, cpu_bus.rdata, ce.we, ce.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic exp_line(input logic [15:0] base);
        exp_mem.push_back('{we: 1'b0, addr: base, data: 16'h0000});
        exp_mem.push_back('{we: 1'b0, addr: base | 16'h0001, data: 16'h0000});
    endtask

    task automatic exp_wr(input logic [15:0] addr, input logic [15:0] data);
        exp_mem.push_back('{we: 1'b1, addr: addr, data: data});
        exp_cpu.push_back('{we: 1'b1, data: 16'h0000});
    endtask

    task automatic exp_load(input logic [15:0] data);
        exp_cpu.push_back('{we: 1'b0, data: data});
    endtask

    // Issue one access, hold it until cpu_ready, and check the number of stall cycles.
    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              input int exp_waits, input string name);
        int  waits;
        bit  done;
        @(posedge clock);
        #1;
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = we;
        cpu_bus.addr  = addr;
        cpu_bus.wdata = wdata;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            #2;
            if (cpu_bus.ready) done = 1'b1;
            else waits++;
        end
        checks++;
        if (!done || waits != exp_waits) begin
            failures++;
            $display("FAIL %s stall cycles: got %0d (done=%0b) want %0d", name, waits, done, exp_waits);
        end
        @(posedge clock);
        #1;
        cpu_bus.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset         = 1'b0;
        flush         = 1'b0;
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = 1'b0;
        cpu_bus.addr  = 16'h0012;
        cpu_bus.wdata = 16'h0000;

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        check("rst_cpu_ready", 16'(cpu_bus.ready), 16'h0);
        check("rst_mem_req", 16'(mem_bus.req), 16'h0);
        check("rst_mem_we", 16'(mem_bus.we), 16'h0);
        check("rst_mem_addr", mem_bus.addr, 16'h0000);
        check("rst_mem_wdata", mem_bus.wdata, 16'h0000);
        cpu_bus.req = 1'b0;
        reset       = 1'b1;
        @(posedge clock);
        #1;
        check("idle_ready", 16'(cpu_bus.ready), 16'h1);

        // Cold miss with two-word refill, then a same-cycle hit on the other word.
        exp_line(16'h0012);
        exp_load(16'hAAAA);
        cpu_access(1'b0, 16'h0012, 16'h0, 7, "t1_cold_load");
        exp_load(16'hBBBB);
        cpu_access(1'b0, 16'h0013, 16'h0, 0, "t1_hit");
`ifdef DCACHE_STATS_EN
        check("t1_hit_cnt", hit_cnt, 16'd1);
        check("t1_miss_cnt", miss_cnt, 16'd1);
`endif

        // Store hit writes through and updates the cached word.
        exp_wr(16'h0012, 16'h1234);
        cpu_access(1'b1, 16'h0012, 16'h1234, 3, "t2_store_hit");
        exp_load(16'h1234);
        cpu_access(1'b0, 16'h0012, 16'h0, 0, "t2_load_hit");

        // Same index, new tag replaces the line.
        exp_line(16'h0212);
        exp_load(16'hCCCC);
        cpu_access(1'b0, 16'h0212, 16'h0, 7, "t3_conflict");
        exp_line(16'h0012);
        exp_load(16'h1234);
        cpu_access(1'b0, 16'h0012, 16'h0, 7, "t3_evicted");

        // Store miss does not allocate.
        exp_wr(16'h0040, 16'h5555);
        cpu_access(1'b1, 16'h0040, 16'h5555, 3, "t4_store_miss");
        exp_line(16'h0040);
        exp_load(16'h5555);
        cpu_access(1'b0, 16'h0040, 16'h0, 7, "t4_load_miss");
        exp_load(16'h4141);
        cpu_access(1'b0, 16'h0041, 16'h0, 0, "t4_hit_word1");

        // Same-cycle memory ack.
        ack_delay = 0;
        exp_line(16'h0212);
        exp_load(16'hDDDD);
        cpu_access(1'b0, 16'h0213, 16'h0, 3, "t4_ack0_refill");
        exp_wr(16'h0213, 16'h7777);
        cpu_access(1'b1, 16'h0213, 16'h7777, 1, "t4_ack0_store");
        exp_load(16'h7777);
        cpu_access(1'b0, 16'h0213, 16'h0, 0, "t4_ack0_hit");
        ack_delay = 2;

        // Flush during a refill: line ends invalid, retried load misses again.
        exp_line(16'h0012);
        exp_line(16'h0012);
        exp_load(16'h1234);
        fork
            cpu_access(1'b0, 16'h0012, 16'h0, 14, "t5_flush_refill");
            begin
                repeat (3) @(posedge clock);
                #1 flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
            end
        join

        // Flush with a request in IDLE stalls one cycle and invalidates the line.
        exp_line(16'h0012);
        exp_load(16'hBBBB);
        fork
            cpu_access(1'b0, 16'h0013, 16'h0, 8, "t5_flush_idle");
            begin
                @(posedge clock);
                #1 flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
            end
        join

        // Reset in the middle of a refill.
        exp_mem.push_back('{we: 1'b0, addr: 16'h0240, data: 16'h0000});
        @(posedge clock);
        #1;
        cpu_bus.req  = 1'b1;
        cpu_bus.we   = 1'b0;
        cpu_bus.addr = 16'h0240;
        repeat (4) @(posedge clock);
        #2;
        check("t6_word1_req", 16'(mem_bus.req), 16'h1);
        check("t6_word1_addr", mem_bus.addr, 16'h0241);
        reset = 1'b0;
        #1;
        check("t6_async_req_drop", 16'(mem_bus.req), 16'h0);
        check("t6_ready_in_reset", 16'(cpu_bus.ready), 16'h0);
`ifdef DCACHE_STATS_EN
        check("t6_miss_cnt_rst", miss_cnt, 16'd0);
`endif
        cpu_bus.req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;

        exp_line(16'h0240);
        exp_load(16'h2400);
        cpu_access(1'b0, 16'h0240, 16'h0, 7, "t6_partial_line");
        exp_line(16'h0012);
        exp_load(16'hBBBB);
        cpu_access(1'b0, 16'h0013, 16'h0, 7, "t6_miss_after_rst");
        exp_line(16'h0040);
        exp_load(16'h5555);
        cpu_access(1'b0, 16'h0040, 16'h0, 7, "t6_miss_after_rst2");
`ifdef DCACHE_STATS_EN
        check("t6_hit_cnt", hit_cnt, 16'd0);
        check("t6_miss_cnt", miss_cnt, 16'd3);
`endif

        repeat (3) @(posedge clock);
        #1;
        check("mem_queue_drained", 16'(exp_mem.size()), 16'h0);
        check("cpu_queue_drained", 16'(exp_cpu.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
